// File: rtl/bank_axi3_mem_slave_if.sv
// bank_axi3_mem_slave_if: AXI3 channel bundle between the bank BIU master and the memory slave.
// Signal suffixes are from the slave's point of view.
interface bank_axi3_mem_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 8
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    logic                  axi_arvalid_i, axi_arready_o;
    logic [ID_WIDTH-1:0]   axi_arid_i;
    logic [ADDR_WIDTH-1:0] axi_araddr_i;
    logic [3:0]            axi_arlen_i;
    logic [2:0]            axi_arsize_i;
    logic [1:0]            axi_arburst_i;
    logic                  axi_rvalid_o, axi_rready_i;
    logic [ID_WIDTH-1:0]   axi_rid_o;
    logic [DATA_WIDTH-1:0] axi_rdata_o;
    logic [1:0]            axi_rresp_o;
    logic                  axi_rlast_o;
    logic                  axi_awvalid_i, axi_awready_o;
    logic [ID_WIDTH-1:0]   axi_awid_i;
    logic [ADDR_WIDTH-1:0] axi_awaddr_i;
    logic [3:0]            axi_awlen_i;
    logic [2:0]            axi_awsize_i;
    logic [1:0]            axi_awburst_i;
    logic                  axi_wvalid_i, axi_wready_o;
    logic [ID_WIDTH-1:0]   axi_wid_i;
    logic [DATA_WIDTH-1:0] axi_wdata_i;
    logic [STRB_WIDTH-1:0] axi_wstrb_i;
    logic                  axi_wlast_i;
    logic                  axi_bvalid_o, axi_bready_i;
    logic [ID_WIDTH-1:0]   axi_bid_o;
    logic [1:0]            axi_bresp_o;

    modport slave (
        input  axi_arvalid_i, axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arsize_i, axi_arburst_i,
        input  axi_rready_i, axi_awvalid_i, axi_awid_i, axi_awaddr_i, axi_awlen_i, axi_awsize_i,
        input  axi_awburst_i, axi_wvalid_i, axi_wid_i, axi_wdata_i, axi_wstrb_i, axi_wlast_i, axi_bready_i,
        output axi_arready_o, axi_rvalid_o, axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o,
        output axi_awready_o, axi_wready_o, axi_bvalid_o, axi_bid_o, axi_bresp_o
    );

    modport master (
        output axi_arvalid_i, axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arsize_i, axi_arburst_i,
        output axi_rready_i, axi_awvalid_i, axi_awid_i, axi_awaddr_i, axi_awlen_i, axi_awsize_i,
        output axi_awburst_i, axi_wvalid_i, axi_wid_i, axi_wdata_i, axi_wstrb_i, axi_wlast_i, axi_bready_i,
        input  axi_arready_o, axi_rvalid_o, axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o,
        input  axi_awready_o, axi_wready_o, axi_bvalid_o, axi_bid_o, axi_bresp_o
    );
endinterface

// File: rtl/bank_axi3_mem_slave.sv
// bank_axi3_mem_slave: line-granular AXI3 memory responder for single-beat 32-byte bursts.
// Independent read and write FSMs share one line array; reads see pre-write data on a collision.
module bank_axi3_mem_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int MEM_DEPTH  = 1024,
    parameter int RD_LATENCY = 2
) (
    input logic clk_i,
    input logic rst_i,
    bank_axi3_mem_slave_if.slave axi
);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam int CW = RD_LATENCY > 1 ? $clog2(RD_LATENCY) : 1;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;
    typedef enum logic [1:0] {W_COLLECT, W_COMMIT, W_RESP} wstate_t;

    typedef struct packed {
        rstate_t               st;
        logic [CW-1:0]         cnt;
        logic [ID_WIDTH-1:0]   id;
        logic [IW-1:0]         idx;
        logic [1:0]            err;
        logic                  valid;
        logic                  last;
        logic [1:0]            resp;
        logic [DATA_WIDTH-1:0] data;
    } rd_t;

    typedef struct packed {
        wstate_t               st;
        logic                  aw_held;
        logic                  w_held;
        logic [ID_WIDTH-1:0]   aw_id;
        logic [IW-1:0]         idx;
        logic [1:0]            aw_err;
        logic [ID_WIDTH-1:0]   w_id;
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
        logic                  last;
        logic                  bvalid;
        logic [1:0]            bresp;
    } wr_t;

    rd_t r_q, r_d;
    wr_t w_q, w_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [1:0] commit_resp;
    logic aw_rdy, w_rdy, unused_burst;

    // Decode error outranks a malformed burst; only single 32-byte beats are legal.
    function automatic logic [1:0] decode(input logic [ADDR_WIDTH-1:0] a, input logic [3:0] len,
                                          input logic [2:0] size);
        return (a >> (5 + IW)) != '0 ? DECERR : (len != 4'd0 || size != 3'b101) ? SLVERR : OKAY;
    endfunction

    assign unused_burst = ^{axi.axi_arburst_i, axi.axi_awburst_i};
    assign aw_rdy       = w_q.st == W_COLLECT && !w_q.aw_held;
    assign w_rdy        = w_q.st == W_COLLECT && !w_q.w_held;
    assign commit_resp  = w_q.aw_err != OKAY ? w_q.aw_err :
                          (w_q.w_id != w_q.aw_id || !w_q.last) ? SLVERR : OKAY;

    assign axi.axi_arready_o = r_q.st == R_IDLE;
    assign axi.axi_rvalid_o  = r_q.valid;
    assign axi.axi_rid_o     = r_q.id;
    assign axi.axi_rdata_o   = r_q.data;
    assign axi.axi_rresp_o   = r_q.resp;
    assign axi.axi_rlast_o   = r_q.last;
    assign axi.axi_awready_o = aw_rdy;
    assign axi.axi_wready_o  = w_rdy;
    assign axi.axi_bvalid_o  = w_q.bvalid;
    assign axi.axi_bid_o     = w_q.aw_id;
    assign axi.axi_bresp_o   = w_q.bresp;

    always_comb begin
        r_d = r_q;
        if (r_q.st == R_IDLE && axi.axi_arvalid_i) begin
            r_d.st  = R_WAIT;
            r_d.cnt = CW'(RD_LATENCY - 1);
            r_d.id  = axi.axi_arid_i;
            r_d.idx = axi.axi_araddr_i[5+IW-1:5];
            r_d.err = decode(axi.axi_araddr_i, axi.axi_arlen_i, axi.axi_arsize_i);
        end else if (r_q.st == R_WAIT) begin
            r_d.cnt   = r_q.cnt - 1'b1;
            r_d.st    = r_q.cnt == '0 ? R_RESP : R_WAIT;
            r_d.valid = r_q.cnt == '0;
            r_d.last  = r_q.cnt == '0;
            r_d.resp  = r_q.cnt == '0 ? r_q.err : r_q.resp;
            r_d.data  = r_q.cnt != '0 ? r_q.data : r_q.err != OKAY ? '0 : mem_q[r_q.idx];
        end else if (r_q.st == R_RESP && axi.axi_rready_i) begin
            r_d.st    = R_IDLE;
            r_d.valid = 1'b0;
            r_d.last  = 1'b0;
        end
    end

    always_comb begin
        w_d = w_q;
        if (w_q.st == W_COLLECT) begin
            if (axi.axi_awvalid_i && aw_rdy) begin
                w_d.aw_held = 1'b1;
                w_d.aw_id   = axi.axi_awid_i;
                w_d.idx     = axi.axi_awaddr_i[5+IW-1:5];
                w_d.aw_err  = decode(axi.axi_awaddr_i, axi.axi_awlen_i, axi.axi_awsize_i);
            end
            if (axi.axi_wvalid_i && w_rdy) begin
                w_d.w_held = 1'b1;
                w_d.w_id   = axi.axi_wid_i;
                w_d.data   = axi.axi_wdata_i;
                w_d.strb   = axi.axi_wstrb_i;
                w_d.last   = axi.axi_wlast_i;
            end
            w_d.st = w_d.aw_held && w_d.w_held ? W_COMMIT : W_COLLECT;
        end else if (w_q.st == W_COMMIT) begin
            w_d.st     = W_RESP;
            w_d.bvalid = 1'b1;
            w_d.bresp  = commit_resp;
        end else if (axi.axi_bready_i) begin
            w_d.st      = W_COLLECT;
            w_d.bvalid  = 1'b0;
            w_d.aw_held = 1'b0;
            w_d.w_held  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_q <= '0;
            w_q <= '0;
        end else begin
            r_q <= r_d;
            w_q <= w_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_q.st == W_COMMIT && commit_resp == OKAY)
            for (int i = 0; i < STRB_WIDTH; i++)
                if (w_q.strb[i]) mem_q[w_q.idx][8*i +: 8] <= w_q.data[8*i +: 8];
    end
endmodule
